// File: rtl/mandel_scan_dispatch.sv
// ---------------------------------------------------------------------------
// mandel_scan_dispatch
//
// This block scans a COLS x ROWS pixel tile in raster order. For each pixel it
// hands the complex coordinate to one of NUM_LANES external Mandelbrot
// iterator lanes. It collects each lane's escape count and writes the count to
// the frame-buffer write port, tagged with the linear pixel address
// (row*cols + col). Writes may arrive out of raster order. Every pixel is
// written exactly once.
//
// Optional feature: define MANDEL_SCAN_PERF_EN to add two performance
// counters:
//   perf_iter_total - sum of every escape count written out
//   perf_cycles     - number of cycles spent in RUN and DRAIN
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             begin a scan (accepted only in IDLE)
//   init_x, init_y    signed top-left coordinate, latched on start
//   x_incr, y_incr    signed per-column / per-row step, latched on start
//   cols, rows        tile dimensions, latched on start
//   busy, done        scan in progress / last scan completed
//   lane_start        one-hot single-cycle dispatch pulse
//   lane_cr, lane_ci  shared coordinate bus, valid with lane_start
//   lane_done         per-lane completion pulse
//   lane_count        per-lane escape counts, valid with lane_done
//   wr_valid/ready    frame-buffer write handshake
//   wr_addr, wr_data  linear pixel address and escape count
// ---------------------------------------------------------------------------
module mandel_scan_dispatch #(
    parameter int NUM_LANES = 4,
    parameter int COORD_W   = 27,
    parameter int DIM_W     = 10,
    parameter int ADDR_W    = 17,
    parameter int ITER_W    = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [COORD_W-1:0]     init_x,
    input  logic signed [COORD_W-1:0]     init_y,
    input  logic signed [COORD_W-1:0]     x_incr,
    input  logic signed [COORD_W-1:0]     y_incr,
    input  logic        [DIM_W-1:0]       cols,
    input  logic        [DIM_W-1:0]       rows,
    output logic                          busy,
    output logic                          done,
    output logic        [NUM_LANES-1:0]   lane_start,
    output logic signed [COORD_W-1:0]     lane_cr,
    output logic signed [COORD_W-1:0]     lane_ci,
    input  logic        [NUM_LANES-1:0]   lane_done,
    input  logic [NUM_LANES*ITER_W-1:0]   lane_count,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic        [ADDR_W-1:0]      wr_addr,
    output logic        [ITER_W-1:0]      wr_data
`ifdef MANDEL_SCAN_PERF_EN
    ,
    output logic        [31:0]            perf_iter_total,
    output logic        [31:0]            perf_cycles
`endif
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state, state_next;

    // View registers, captured on start.
    logic signed [COORD_W-1:0] init_x_q, x_incr_q, y_incr_q;
    logic        [DIM_W-1:0]   cols_q, rows_q;

    // Scan position.
    logic signed [COORD_W-1:0] cur_x, cur_y;
    logic        [DIM_W-1:0]   col, row;
    logic        [ADDR_W-1:0]  pix_addr;

    // Per-lane bookkeeping. A lane stays busy from dispatch until its result
    // has been accepted by the frame buffer.
    logic [NUM_LANES-1:0] lane_busy, pending;
    logic [ADDR_W-1:0]    tag    [NUM_LANES];
    logic [ITER_W-1:0]    result [NUM_LANES];

    // Writeback arbitration.
    logic [LANE_W-1:0] rr_ptr, wr_sel;

    // Combinational decisions.
    logic              free_valid, grant_valid;
    logic [LANE_W-1:0] free_idx, grant_idx;
    logic              dispatch, line_end, last_pix;
    logic              start_scan, start_empty, done_set, wr_fire;

    assign wr_fire  = wr_valid && wr_ready;
    // End-of-line detection uses the integer column counter. Coordinates are
    // never compared.
    assign line_end = (col == cols_q - DIM_W'(1));
    assign last_pix = line_end && (row == rows_q - DIM_W'(1));

    // Pick the lowest-index lane that is idle.
    always_comb begin
        // NOTE: give every combinational output a default value first, so no
        // path through the block leaves it unassigned and infers a latch.
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!free_valid && !lane_busy[i]) begin
                free_valid = 1'b1;
                free_idx   = LANE_W'(i);
            end
        end
    end

    // Round-robin search over pending results, starting at rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!grant_valid && pending[(int'(rr_ptr) + k) % NUM_LANES]) begin
                grant_valid = 1'b1;
                grant_idx   = LANE_W'((int'(rr_ptr) + k) % NUM_LANES);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the clock edge.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic and dispatch outputs.
    always_comb begin
        state_next  = state;
        dispatch    = 1'b0;
        start_scan  = 1'b0;
        start_empty = 1'b0;
        done_set    = 1'b0;
        lane_start  = '0;
        lane_cr     = '0;
        lane_ci     = '0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start) begin
                    // A start with an empty tile completes at once, with
                    // no dispatches and no writes.
                    if (cols == '0 || rows == '0) begin
                        start_empty = 1'b1;
                    end else begin
                        start_scan = 1'b1;
                        state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (free_valid) begin
                    dispatch   = 1'b1;
                    lane_start = NUM_LANES'(1) << free_idx;
                    lane_cr    = cur_x;
                    lane_ci    = cur_y;
                    if (last_pix) state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A lane with a granted write is still pending, so this test
                // also waits for the final handshake.
                if (lane_busy == '0 && pending == '0) begin
                    state_next = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: scan counters, lane bookkeeping and the writeback register.
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            init_x_q  <= '0;
            x_incr_q  <= '0;
            y_incr_q  <= '0;
            cols_q    <= '0;
            rows_q    <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            col       <= '0;
            row       <= '0;
            pix_addr  <= '0;
            lane_busy <= '0;
            pending   <= '0;
            rr_ptr    <= '0;
            wr_sel    <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            // NOTE: these per-lane arrays are a handful of flops, not RAM,
            // so resetting them costs nothing and keeps the outputs
            // deterministic.
            for (int i = 0; i < NUM_LANES; i++) begin
                tag[i]    <= '0;
                result[i] <= '0;
            end
        end else begin
            if (start_scan) begin
                init_x_q <= init_x;
                x_incr_q <= x_incr;
                y_incr_q <= y_incr;
                cols_q   <= cols;
                rows_q   <= rows;
                cur_x    <= init_x;
                cur_y    <= init_y;
                col      <= '0;
                row      <= '0;
                pix_addr <= '0;
                done     <= 1'b0;
            end
            if (start_empty || done_set) done <= 1'b1;

            // Advance the raster position after each dispatch. Coordinates
            // wrap at COORD_W and are never saturated.
            if (dispatch) begin
                tag[free_idx] <= pix_addr;
                pix_addr      <= pix_addr + ADDR_W'(1);
                if (line_end) begin
                    col   <= '0;
                    cur_x <= init_x_q;
                    row   <= row + DIM_W'(1);
                    cur_y <= cur_y + y_incr_q;
                end else begin
                    col   <= col + DIM_W'(1);
                    cur_x <= cur_x + x_incr_q;
                end
            end

            for (int i = 0; i < NUM_LANES; i++) begin
                if (dispatch && free_idx == LANE_W'(i)) lane_busy[i] <= 1'b1;
                // Ignore a completion on an idle lane, or on a lane whose
                // result is still waiting to be written.
                if (lane_done[i] && lane_busy[i] && !pending[i]) begin
                    result[i]  <= lane_count[i*ITER_W +: ITER_W];
                    pending[i] <= 1'b1;
                end
                // After the handshake the lane is free. It can take a new
                // pixel from the next cycle on.
                if (wr_fire && wr_sel == LANE_W'(i)) begin
                    pending[i]   <= 1'b0;
                    lane_busy[i] <= 1'b0;
                end
            end

            // The write is registered. It is loaded only when the port is
            // empty, so wr_addr and wr_data hold steady until wr_ready.
            if (wr_fire) begin
                wr_valid <= 1'b0;
            end else if (!wr_valid && grant_valid) begin
                wr_valid <= 1'b1;
                wr_sel   <= grant_idx;
                wr_addr  <= tag[grant_idx];
                wr_data  <= result[grant_idx];
                rr_ptr   <= (grant_idx == LANE_W'(NUM_LANES - 1)) ? '0
                                                                  : grant_idx + LANE_W'(1);
            end
        end
    end

`ifdef MANDEL_SCAN_PERF_EN
    // Both counters clear on an accepted start and hold their value in IDLE.
    always_ff @(posedge clk) begin
        if (reset || start_scan || start_empty) begin
            perf_iter_total <= '0;
            perf_cycles     <= '0;
        end else begin
            if (busy)    perf_cycles     <= perf_cycles + 32'd1;
            if (wr_fire) perf_iter_total <= perf_iter_total + 32'(wr_data);
        end
    end
`endif

endmodule
